// File: rtl/gin_pkg.sv
// Shared types for the GIN bus scatter block: FSM states and the buffered word layout.
package gin_pkg;

  localparam int GIN_ID_BITS   = 5;
  localparam int GIN_DATA_BITS = 32;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_CFG   = 2'd2
  } gin_scatter_state_e;

  typedef struct packed {
    logic [GIN_ID_BITS-1:0]   tag;
    logic [GIN_DATA_BITS-1:0] data;
  } gin_entry_t;

endpackage

// File: rtl/gin_fifo2.sv
// Two-entry synchronous FIFO of tagged words. Push on full and pop on empty are ignored.
module gin_fifo2
  import gin_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  gin_entry_t wdata,
  output gin_entry_t rdata,
  output logic       full,
  output logic       empty
);

  gin_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; contents are cleared on reset so the bus fields read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/gin_bus_scatter.sv
// GIN bus transmitter: buffers tagged words onto the broadcast bus, drops words nobody
// accepts within TIMEOUT_CYC stall cycles, and runs the controller ID-programming pass.
module gin_bus_scatter
  import gin_pkg::*;
#(
  parameter int ID_SIZE     = GIN_ID_BITS,
  parameter int DATA_BITS   = GIN_DATA_BITS,
  parameter int NUM_CTRL    = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_SIZE-1:0]   in_tag,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 bus_valid,
  input  logic                 bus_ready,
  output logic [ID_SIZE-1:0]   bus_tag,
  output logic [DATA_BITS-1:0] bus_data,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ID_SIZE-1:0]   cfg_id,
  output logic [NUM_CTRL-1:0]  set_id,
  output logic [ID_SIZE-1:0]   id_out,
  output logic                 cfg_done,
  output logic                 drop_err,
  output logic [ID_SIZE-1:0]   drop_tag
);

  localparam int IDX_W = $clog2(NUM_CTRL);
  // A zero timeout still needs a 1-bit timer so the declaration stays legal.
  localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CTRL - 1);

  gin_scatter_state_e state;
  logic               cfg_pending;
  logic [IDX_W-1:0]   idx;
  logic [TMR_W-1:0]   timer;

  gin_entry_t wentry;
  gin_entry_t head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       stall;
  logic       drop;

  assign wentry.tag  = in_tag;
  assign wentry.data = in_data;

  gin_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Upstream acceptance only looks at current occupancy, never at bus_ready, so a full
  // FIFO refuses even in a cycle where it also pops.
  assign in_ready  = !rst && (state == S_RUN) && !cfg_pending && !full;
  assign bus_valid = !empty && (state != S_CFG);
  assign bus_tag   = head.tag;
  assign bus_data  = head.data;
  assign cfg_ready = (state == S_CFG);

  assign push  = in_valid && in_ready;
  assign stall = bus_valid && !bus_ready;
  assign drop  = (TIMEOUT_CYC != 0) && stall && (timer == TMR_LAST);
  assign pop   = bus_valid && (bus_ready || drop);

  // Stall timer: counts consecutive refused cycles of the head word, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (pop) begin
      timer <= '0;
    end else if (stall && (timer != '1)) begin
      timer <= timer + 1'b1;
    end
  end

  // Drop report: pulse one cycle after the head is discarded and remember its tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err <= 1'b0;
      drop_tag <= '0;
    end else begin
      drop_err <= drop;
      if (drop) drop_tag <= head.tag;
    end
  end

  // Mode FSM with the ID-programming counter and its registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      cfg_pending <= 1'b0;
      idx         <= '0;
      set_id      <= '0;
      id_out      <= '0;
      cfg_done    <= 1'b0;
    end else begin
      set_id   <= '0;
      cfg_done <= 1'b0;
      case (state)
        S_RUN: begin
          if (cfg_start) begin
            cfg_pending <= 1'b1;
            idx         <= '0;
            // A word pushed in the start cycle still has to drain first.
            state       <= (empty && !push) ? S_CFG : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (empty) begin
            state <= S_CFG;
            idx   <= '0;
          end
        end
        S_CFG: begin
          if (cfg_valid) begin
            set_id <= NUM_CTRL'(1) << idx;
            id_out <= cfg_id;
            if (idx == IDX_LAST) begin
              cfg_done    <= 1'b1;
              cfg_pending <= 1'b0;
              idx         <= '0;
              state       <= S_RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_gin_bus_scatter.sv
// Self-checking bench for gin_bus_scatter: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_gin_bus_scatter;

  localparam int IDW = 5;
  localparam int DW  = 32;
  localparam int NC  = 8;
  localparam int TO  = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [IDW-1:0] in_tag = '0;
  logic [DW-1:0]  in_data = '0;
  logic           bus_valid;
  logic           bus_ready = 1'b0;
  logic [IDW-1:0] bus_tag;
  logic [DW-1:0]  bus_data;
  logic           cfg_start = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [IDW-1:0] cfg_id = '0;
  logic [NC-1:0]  set_id;
  logic [IDW-1:0] id_out;
  logic           cfg_done;
  logic           drop_err;
  logic [IDW-1:0] drop_tag;

  always #5 clk = ~clk;

  gin_bus_scatter #(
    .ID_SIZE(IDW), .DATA_BITS(DW), .NUM_CTRL(NC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_tag(bus_tag), .bus_data(bus_data),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_id(cfg_id),
    .set_id(set_id), .id_out(id_out), .cfg_done(cfg_done),
    .drop_err(drop_err), .drop_tag(drop_tag)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a word queue plus the mode/programming bookkeeping.
  typedef struct {
    logic [IDW-1:0] tag;
    logic [DW-1:0]  data;
  } word_t;

  word_t          q[$];
  int             mode;      // 0 running, 1 draining, 2 programming IDs
  bit             pend;
  int             idx;
  int             stall_n;
  logic [NC-1:0]  m_set_id;
  logic [IDW-1:0] m_id_out;
  logic [IDW-1:0] m_drop_tag;
  logic           m_cfg_done;
  logic           m_drop_err;
  bit             last_push;

  function automatic logic exp_in_ready();
    return !rst && mode == 0 && !pend && q.size() < 2;
  endfunction

  function automatic logic exp_bus_valid();
    return q.size() > 0 && mode != 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(exp_in_ready()));
    chk("bus_valid", 64'(bus_valid), 64'(exp_bus_valid()));
    if (exp_bus_valid()) begin
      chk("bus_tag", 64'(bus_tag), 64'(q[0].tag));
      chk("bus_data", 64'(bus_data), 64'(q[0].data));
    end
    chk("cfg_ready", 64'(cfg_ready), 64'(mode == 2));
    chk("set_id", 64'(set_id), 64'(m_set_id));
    chk("id_out", 64'(id_out), 64'(m_id_out));
    chk("cfg_done", 64'(cfg_done), 64'(m_cfg_done));
    chk("drop_err", 64'(drop_err), 64'(m_drop_err));
    chk("drop_tag", 64'(drop_tag), 64'(m_drop_tag));
  endtask

  task automatic model_reset();
    q.delete();
    mode = 0; pend = 0; idx = 0; stall_n = 0;
    m_set_id = '0; m_id_out = '0; m_drop_tag = '0;
    m_cfg_done = 1'b0; m_drop_err = 1'b0;
    last_push = 0;
  endtask

  // Advance the model across one clock edge using the inputs the DUT sampled.
  task automatic model_update();
    bit bv, push, stall, drop, pop;
    word_t w;
    if (rst) begin
      model_reset();
      return;
    end
    bv    = exp_bus_valid();
    push  = in_valid && exp_in_ready();
    stall = bv && !bus_ready;
    drop  = stall && (TO != 0) && (stall_n == TO - 1);
    pop   = bv && (bus_ready || drop);
    m_drop_err = drop;
    if (drop) m_drop_tag = q[0].tag;
    if (pop) stall_n = 0;
    else if (stall) stall_n++;
    m_set_id = '0;
    m_cfg_done = 1'b0;
    case (mode)
      0: if (cfg_start) begin
           pend = 1; idx = 0;
           mode = (q.size() == 0 && !push) ? 2 : 1;
         end
      1: if (q.size() == 0) begin mode = 2; idx = 0; end
      default: if (cfg_valid) begin
           m_set_id = NC'(1 << idx);
           m_id_out = cfg_id;
           if (idx == NC - 1) begin
             m_cfg_done = 1'b1; pend = 0; mode = 0; idx = 0;
           end else idx++;
         end
    endcase
    if (pop) void'(q.pop_front());
    if (push) begin
      w.tag = in_tag; w.data = in_data;
      q.push_back(w);
    end
    last_push = push;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    in_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic offer(input logic [IDW-1:0] t);
    in_valid = 1'b1; in_tag = t; in_data = $urandom;
  endtask

  int widx;
  logic [IDW-1:0] bp_tags [3];

  initial begin
    // Bring the DUT out of its unknown power-up state before any comparison.
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    ticks(2);
    rst = 1'b0;
    ticks(2);

    // Back-to-back stream to a matching controller.
    bus_ready = 1'b1;
    offer(5'd3); tick();
    offer(5'd5); tick();
    offer(5'd3); tick();
    idle(); ticks(3);

    // Backpressure: three words offered while the bus refuses for ten cycles.
    bp_tags[0] = 5'd1; bp_tags[1] = 5'd9; bp_tags[2] = 5'd17;
    bus_ready = 1'b0;
    widx = 0;
    offer(bp_tags[0]);
    repeat (10) begin
      tick();
      if (last_push) begin
        widx++;
        if (widx < 3) offer(bp_tags[widx]); else in_valid = 1'b0;
      end
    end
    bus_ready = 1'b1;
    repeat (6) begin
      tick();
      if (last_push) begin
        widx++;
        if (widx < 3) offer(bp_tags[widx]); else in_valid = 1'b0;
      end
    end
    idle(); ticks(2);

    // Unmatched tag: dropped after the timeout, then a normal word follows.
    bus_ready = 1'b0;
    offer(5'd31); tick();
    idle(); ticks(TO + 2);
    bus_ready = 1'b1;
    offer(5'd2); tick();
    idle(); ticks(3);

    // Full configuration pass from an empty FIFO.
    cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      cfg_valid = 1'b1; cfg_id = IDW'(NC - 1 - i); tick();
    end
    cfg_valid = 1'b0; ticks(3);

    // cfg_start with two words stuck behind a refusing bus.
    bus_ready = 1'b0;
    offer(5'd4); tick();
    offer(5'd6); tick();
    idle();
    cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_id = 5'd12;
    ticks(2 * TO + 4);
    for (int i = 0; i < NC; i++) begin
      cfg_id = IDW'($urandom); tick();
    end
    idle(); bus_ready = 1'b1; ticks(3);

    // Reset in the middle of a programming pass, then restart it.
    cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_id = IDW'(20 + i); tick();
    end
    cfg_valid = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; ticks(2);
    cfg_start = 1'b1; tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_id = 5'd11; tick();
    cfg_valid = 1'b0; ticks(2);
    for (int i = 0; i < NC - 1; i++) begin
      cfg_valid = 1'b1; cfg_id = IDW'(i); tick();
    end
    idle(); ticks(2);

    // Random traffic with occasional config passes and resets.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_tag    = IDW'($urandom);
      in_data   = $urandom;
      bus_ready = ($urandom_range(0, 9) < 6);
      cfg_start = ($urandom_range(0, 59) == 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_id    = IDW'($urandom);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; idle(); ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
